// File: rtl/alu_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter_if
// Description : Bundle of the two request channels, the tagged response
//               channel and the ALU-side signals of the shared-ALU arbiter.
//               The slave modport is the arbiter's view; the master modport
//               is the view of the surrounding requesters, consumer and ALU.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             req0_valid;
  logic             req0_ready;
  logic [3:0]       req0_sel;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;

  logic             req1_valid;
  logic             req1_ready;
  logic [3:0]       req1_sel;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_zero;

  logic [3:0]       ALU_SEL;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;

  logic             busy;

  modport slave (
    input  req0_valid, req0_sel, req0_a, req0_b,
    input  req1_valid, req1_sel, req1_a, req1_b,
    input  rsp_ready, alu_result, alu_zero,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_result, rsp_zero,
    output ALU_SEL, alu_a, alu_b, busy
  );

  modport master (
    output req0_valid, req0_sel, req0_a, req0_b,
    output req1_valid, req1_sel, req1_a, req1_b,
    output rsp_ready, alu_result, alu_zero,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_result, rsp_zero,
    input  ALU_SEL, alu_a, alu_b, busy
  );
endinterface
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Round-robin arbiter/sequencer in front of one shared ALU.
//               Grants one of two requesters, holds the operands on the ALU
//               for ALU_LAT cycles, captures result and zero flag, and
//               returns them on a single tagged response channel.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
  parameter int WIDTH   = 32,
  parameter int ALU_LAT = 1
) (
  input  wire logic       clk,
  input  wire logic       rst,
  alu_arbiter_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(ALU_LAT);

  state_t           state_q, state_d;
  logic [3:0]       op_sel_q, op_sel_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic             op_id_q, op_id_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             last_grant_q, last_grant_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic             rsp_id_q, rsp_id_d;

  logic             grant0;
  logic             grant1;

  // Round-robin grant, only offered in IDLE; ready is held low during reset.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == IDLE && !rst) begin
      if (bus.req0_valid && bus.req1_valid) begin
        grant0 = last_grant_q;
        grant1 = !last_grant_q;
      end else begin
        grant0 = bus.req0_valid;
        grant1 = bus.req1_valid;
      end
    end
  end

  // Next-state and datapath update for the IDLE/EXEC/RESP sequencer.
  always_comb begin
    state_d      = state_q;
    op_sel_d     = op_sel_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    op_id_d      = op_id_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_id_d     = rsp_id_q;
    case (state_q)
      IDLE: begin
        if (grant0 || grant1) begin
          op_sel_d     = grant1 ? bus.req1_sel : bus.req0_sel;
          op_a_d       = grant1 ? bus.req1_a   : bus.req0_a;
          op_b_d       = grant1 ? bus.req1_b   : bus.req0_b;
          op_id_d      = grant1;
          last_grant_d = grant1;
          cnt_d        = CNT_INIT;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        cnt_d = cnt_q - 4'd1;
        // The ALU has had op_* for ALU_LAT cycles once cnt reaches 1.
        if (cnt_q == 4'd1) begin
          rsp_result_d = bus.alu_result;
          rsp_zero_d   = bus.alu_zero;
          rsp_id_d     = op_id_q;
          state_d      = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; last_grant resets to 1 so req0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      op_sel_q     <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_id_q      <= 1'b0;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_id_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_sel_q     <= op_sel_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      op_id_q      <= op_id_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_id_q     <= rsp_id_d;
    end
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.rsp_valid  = (state_q == RESP);
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_zero   = rsp_zero_q;
  assign bus.ALU_SEL    = op_sel_q;
  assign bus.alu_a      = op_a_q;
  assign bus.alu_b      = op_b_q;
  assign bus.busy       = (state_q != IDLE);

endmodule
`default_nettype wire

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester arbiter and sequencer for the shared ALU. It accepts operation requests (ALU select code plus two operands) from two independent requesters and grants them round-robin. It drives the single ALU instance, waits a fixed ALU latency, and returns the result and zero flag on one tagged response channel. It sits between the issuing units and the ALU and does not decode operations.

## Interface
Parameters:
- WIDTH, 32, operand/result width.
- ALU_LAT, 1, ALU result latency in cycles (legal 1..15).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 accepted this cycle when valid&ready.
- req0_sel  in  4  ALU_SEL code for requester 0.
- req0_a, req0_b  in  WIDTH  operands for requester 0.
- req1_valid, req1_ready, req1_sel, req1_a, req1_b: same widths and meanings, for requester 1.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer takes the response.
- rsp_id  out  1  requester that owns the response.
- rsp_result  out  WIDTH  captured ALU result.
- rsp_zero  out  1  captured ALU zero flag.
- ALU_SEL  out  4  select code to the ALU.
- alu_a, alu_b  out  WIDTH  operands to the ALU.
- alu_result  in  WIDTH  ALU result.
- alu_zero  in  1  ALU zero flag.
- busy  out  1  high whenever state is not IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP. Registers: op_sel, op_a, op_b, op_id, cnt[3:0], last_grant, rsp_result, rsp_zero, rsp_id.
- **IDLE grant** (combinational):
  - Only reqN_valid high: grant N.
  - Both high: grant !last_grant.
  - Neither high: no grant.
- reqN_ready = (state==IDLE) && grant==N. It is never high in EXEC or RESP.
- **Accept** (reqN_valid && reqN_ready at an edge):
  - Latch sel/a/b into op_*.
  - op_id<=N, last_grant<=N, cnt<=ALU_LAT.
  - Go to EXEC.
- **EXEC**:
  - ALU_SEL/alu_a/alu_b = op_sel/op_a/op_b, stable for the whole state.
  - cnt decrements each cycle.
  - At the edge where cnt==1: rsp_result<=alu_result, rsp_zero<=alu_zero, rsp_id<=op_id; go to RESP.
- **RESP**:
  - rsp_valid=1. rsp_* held stable until rsp_ready.
  - On rsp_valid && rsp_ready go to IDLE.
  - No new request is accepted in the handshake cycle.
- ALU_SEL/alu_a/alu_b are registered (op_*) and hold their last issued values outside EXEC.
- Select codes pass through unchecked. Undefined codes give whatever the ALU returns.
- A requester may drop valid before it is granted; nothing is latched and arbitration is re-evaluated every IDLE cycle.
- **Reset values**:
  - State: IDLE.
  - All outputs 0 (req*_ready, rsp_valid, rsp_id, rsp_result, rsp_zero, ALU_SEL, alu_a, alu_b, busy).
  - last_grant=1, so req0 wins the first contention.
- **Reset mid-operation** (EXEC or RESP): next cycle is IDLE with reset values, and the in-flight operation is discarded with no response.

## Timing
- Accept at edge k.
- EXEC occupies cycles k+1 .. k+ALU_LAT; the ALU sees op_* from cycle k+1.
- Result sampled at the end of cycle k+ALU_LAT.
- rsp_valid high from cycle k+ALU_LAT+1.
- Accept-to-rsp_valid latency: ALU_LAT+1 cycles.
- With rsp_ready tied high, minimum issue interval is ALU_LAT+2 cycles (accept, ALU_LAT EXEC, one RESP, then IDLE re-grant).
- busy is high from cycle k+1 through the RESP handshake cycle.

## Test plan
All scenarios use ALU_LAT=1 with a combinational bench ALU model (0000 AND, 0001 OR, 0010 add, 0110 sub, 0111 slt).
1. **Reset:** rst high for 2 cycles with both valids high → all outputs 0 during reset. The first cycle after reset gives req0_ready=1, req1_ready=0.
2. **Single request:** req0 sel=0010 a=5 b=7 → accepted at edge k; rsp_valid at k+2 with rsp_result=12, rsp_zero=0, rsp_id=0.
3. **Contention:** req0 (0110, 9, 9) and req1 (0001, 0x0F, 0xF0) valid together → req0 served first (result 0, zero 1, id 0), then req1 (result 0xFF, zero 0, id 1).
4. **Fairness:** both valids held high for 4 operations with rsp_ready=1 → rsp_id sequence 0,1,0,1, and accepts spaced exactly 3 cycles apart.
5. **Backpressure:** rsp_ready low for 5 cycles during RESP → rsp_valid and rsp_result stay stable, both req*_ready stay 0, busy=1. IDLE follows the ready handshake.
6. **Reset in EXEC:** rst asserted in the cycle after req1 is accepted → state IDLE the next cycle, rsp_valid never rises for that operation, and the next contention grants req0.
